// File: rtl/evp_fsm_if.sv
// evp_fsm_if: EVP instruction bus bundling start/operands, N/S RAM read ports and FIFO result outputs
// master: evp_fsm side (drives RAM reads, strobes, result/status)
// slave:  environment side (drives start, A, x and RAM read data)
interface evp_fsm_if;
  logic        start_evp;
  logic [2:0]  A;
  logic [15:0] x;
  logic [4:0]  N_in;
  logic [15:0] S_in;
  logic        en_rd_N;
  logic [2:0]  rd_addr_N;
  logic        en_rd_S;
  logic [6:0]  rd_addr_S;
  logic        done_evp;
  logic        fifo_wr_en_r;
  logic        fifo_wr_en_s;
  logic [31:0] result;
  logic [31:0] status;
  modport master (
    input  start_evp, A, x, N_in, S_in,
    output en_rd_N, rd_addr_N, en_rd_S, rd_addr_S,
    output done_evp, fifo_wr_en_r, fifo_wr_en_s, result, status
  );
  modport slave (
    output start_evp, A, x, N_in, S_in,
    input  en_rd_N, rd_addr_N, en_rd_S, rd_addr_S,
    input  done_evp, fifo_wr_en_r, fifo_wr_en_s, result, status
  );
endinterface

// File: rtl/evp_fsm.sv
// evp_fsm: evaluates the degree-d polynomial stored for slot A at signed x by Horner's rule
// clk, rst : clock and asynchronous active-high reset
// bus      : evp_fsm_if.master -- start/A/x in, N/S RAM read ports, done/FIFO strobes, result/status out
module evp_fsm (
  input logic     clk,
  input logic     rst,
  evp_fsm_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_N, CHK_N, MAC, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  addr_n_q, addr_n_d;
  logic [6:0]  addr_s_q, addr_s_d;
  logic [15:0] x_q, x_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [31:0] result_q, result_d;
  logic [31:0] status_q, status_d;
  logic        rd_s;
  logic [6:0]  base;
  logic [47:0] mac;
  logic        fits;
  // slot A's coefficients start at A*11; the latched A doubles as rd_addr_N
  assign base = 7'(addr_n_q) * 7'd11;
  // 48-bit product cannot overflow (|acc*x| <= 2^46), so the sum is exact
  assign mac  = {{16{acc_q[31]}}, acc_q} * {{32{x_q[15]}}, x_q} + {{32{bus.S_in[15]}}, bus.S_in};
  assign fits = &mac[47:31] | ~|mac[47:31];
  always_comb begin
    state_d  = state_q;
    addr_n_d = addr_n_q;
    addr_s_d = addr_s_q;
    x_d      = x_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    status_d = status_q;
    rd_s     = 1'b0;
    case (state_q)
      IDLE: if (bus.start_evp) begin
        addr_n_d = bus.A;
        x_d      = bus.x;
        state_d  = RD_N;
      end
      RD_N: state_d = CHK_N;
      CHK_N: begin
        ovf_d = 1'b0;
        if (bus.N_in > 5'd10) begin
          result_d = '0;
          status_d = 32'd2;
          state_d  = DONE;
        end else begin
          idx_d    = bus.N_in[3:0];
          acc_d    = '0;
          rd_s     = 1'b1;
          addr_s_d = base + 7'(bus.N_in);
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = mac[31:0];
        ovf_d = ovf_q | ~fits;
        if (idx_q == 4'd0) begin
          result_d = mac[31:0];
          status_d = {31'b0, ovf_d};
          state_d  = DONE;
        end else begin
          // next coefficient read overlaps this MAC so S_in arrives without a bubble
          idx_d    = idx_q - 4'd1;
          rd_s     = 1'b1;
          addr_s_d = base + 7'(idx_q) - 7'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_n_q <= '0;
      addr_s_q <= '0;
      x_q      <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      status_q <= '1;
    end else begin
      state_q  <= state_d;
      addr_n_q <= addr_n_d;
      addr_s_q <= addr_s_d;
      x_q      <= x_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end
  assign bus.en_rd_N      = state_q == RD_N;
  assign bus.rd_addr_N    = addr_n_q;
  assign bus.en_rd_S      = rd_s;
  assign bus.rd_addr_S    = addr_s_d;
  assign bus.done_evp     = state_q == DONE;
  assign bus.fifo_wr_en_r = state_q == DONE;
  assign bus.fifo_wr_en_s = state_q == DONE;
  assign bus.result       = result_q;
  assign bus.status       = status_q;
endmodule

// File: tb/tb_evp_fsm.sv
// tb_evp_fsm: randomized and directed checking of evp_fsm against a per-cycle event model
module tb_evp_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  evp_fsm_if bus();
  evp_fsm dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    bit          n;
    int          an;
    bit          s;
    int          as;
    bit          d;
    logic [31:0] res;
    logic [31:0] stat;
    bit          r;
  } ev_t;
  ev_t         ev[int];
  logic [4:0]  nram[8];
  logic [15:0] sram[88];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          next_ok = 0;
  logic [31:0] cur_res = '0;
  logic [31:0] cur_stat = '1;
  int          cur_an = 0;
  int          cur_as = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.en_rd_N) bus.N_in <= nram[bus.rd_addr_N];
    if (bus.en_rd_S) bus.S_in <= sram[bus.rd_addr_S];
  end
  function automatic ev_t get(int k);
    ev_t e = '{default: 0};
    if (ev.exists(k)) e = ev[k];
    return e;
  endfunction
  function automatic void purge(int k);
    int ks[$];
    foreach (ev[i]) if (i >= k) ks.push_back(i);
    foreach (ks[j]) ev.delete(ks[j]);
  endfunction
  // model: polynomial value and the cycle of every visible event for a start accepted in cycle t
  function automatic void accept(int t, logic [2:0] a, logic [15:0] xv);
    int          d = int'(nram[a]);
    int          base = int'(a) * 11;
    longint      acc = 0;
    longint      full;
    bit          ovf = 0;
    int          dn;
    ev_t         e;
    logic [31:0] res, stat;
    e = get(t + 1); e.n = 1; e.an = int'(a); ev[t + 1] = e;
    if (d > 10) begin
      dn = t + 3; res = 0; stat = 2;
    end else begin
      for (int i = 0; i <= d; i++) begin
        e = get(t + 2 + i); e.s = 1; e.as = base + d - i; ev[t + 2 + i] = e;
        full = acc * longint'($signed(xv)) + longint'($signed(sram[base + d - i]));
        if (full > 64'sd2147483647 || full < -64'sd2147483648) ovf = 1;
        acc = longint'(int'(full));
      end
      dn = t + 4 + d; res = 32'(acc); stat = {31'b0, ovf};
    end
    e = get(dn); e.d = 1; e.res = res; e.stat = stat; ev[dn] = e;
    next_ok = dn + 1;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin : cmp
    ev_t e;
    e = get(cyc);
    if (e.r) begin
      cur_an = 0; cur_as = 0; cur_res = '0; cur_stat = '1;
    end
    if (e.n) cur_an = e.an;
    if (e.s) cur_as = e.as;
    if (e.d) begin
      cur_res = e.res; cur_stat = e.stat;
    end
    chk("en_rd_N", 32'(bus.en_rd_N), 32'(e.n));
    chk("rd_addr_N", 32'(bus.rd_addr_N), 32'(cur_an));
    chk("en_rd_S", 32'(bus.en_rd_S), 32'(e.s));
    chk("rd_addr_S", 32'(bus.rd_addr_S), 32'(cur_as));
    chk("done_evp", 32'(bus.done_evp), 32'(e.d));
    chk("fifo_wr_en_r", 32'(bus.fifo_wr_en_r), 32'(e.d));
    chk("fifo_wr_en_s", 32'(bus.fifo_wr_en_s), 32'(e.d));
    chk("result", bus.result, cur_res);
    chk("status", bus.status, cur_stat);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(logic [2:0] a, logic [15:0] xv);
    bus.A = a;
    bus.x = xv;
    bus.start_evp = 1'b1;
    if (!rst && cyc >= next_ok) accept(cyc, a, xv);
    tick();
    bus.start_evp = 1'b0;
  endtask
  task automatic do_reset(int n);
    ev_t e;
    rst = 1'b1;
    purge(cyc);
    e = get(cyc); e.r = 1; ev[cyc] = e;
    repeat (n) tick();
    rst = 1'b0;
    next_ok = cyc;
  endtask
  task automatic run_dir(string name, logic [2:0] a, logic [15:0] xv, logic [31:0] er, logic [31:0] es, int lat);
    int t, got;
    bit seen = 0;
    logic [31:0] r, s;
    while (cyc < next_ok) tick();
    t = cyc;
    start(a, xv);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_evp) begin
        seen = 1; got = cyc; r = bus.result; s = bus.status;
      end
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_timeout: got no done_evp expected done within 40 cycles", name);
    end else begin
      chk({name, "_latency"}, 32'(got - t), 32'(lat));
      chk({name, "_result"}, r, er);
      chk({name, "_status"}, s, es);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    $fatal(1);
  end
  initial begin
    bus.start_evp = 1'b0;
    bus.A = '0;
    bus.x = '0;
    foreach (nram[i]) nram[i] = 5'($urandom_range(0, 10));
    foreach (sram[i]) sram[i] = 16'($urandom);
    tick(); tick();
    rst = 1'b0;
    next_ok = cyc;
    tick();
    nram[2] = 2; sram[22] = 1; sram[23] = 2; sram[24] = 3;
    run_dir("quad", 3'd2, 16'd2, 32'd17, 32'd0, 6);
    nram[0] = 0; sram[0] = 16'hFFFB;
    run_dir("const", 3'd0, 16'd100, 32'hFFFFFFFB, 32'd0, 4);
    nram[5] = 11;
    run_dir("baddeg", 3'd5, 16'd123, 32'd0, 32'd2, 3);
    nram[1] = 2; sram[13] = 16'h7FFF; sram[12] = 0; sram[11] = 0;
    run_dir("ovf", 3'd1, 16'h7FFF, 32'h40017FFF, 32'd1, 6);
    nram[7] = 10;
    for (int i = 77; i <= 87; i++) sram[i] = 16'd1;
    while (cyc < next_ok) tick();
    start(3'd7, 16'd3);
    tick();
    start(3'd2, 16'd9);
    tick();
    do_reset(2);
    chk("status_after_rst", bus.status, 32'hFFFFFFFF);
    chk("done_after_rst", 32'(bus.fifo_wr_en_r), 32'd0);
    run_dir("deg10", 3'd7, 16'd1, 32'd11, 32'd0, 14);
    nram[3] = 1; sram[34] = 2; sram[33] = 5;
    nram[4] = 3; sram[47] = 1; sram[46] = 0; sram[45] = 0; sram[44] = 1;
    run_dir("b2b_a", 3'd3, 16'd3, 32'd11, 32'd0, 5);
    run_dir("b2b_b", 3'd4, 16'hFFFE, 32'hFFFFFFF9, 32'd0, 7);
    repeat (150) begin
      logic [2:0] a;
      while (cyc < next_ok) begin
        if ($urandom_range(0, 4) == 0) start(3'($urandom), 16'($urandom));
        else tick();
      end
      a = 3'($urandom);
      nram[a] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(11, 31)) : 5'($urandom_range(0, 10));
      for (int i = 0; i < 11; i++)
        sram[int'(a) * 11 + i] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 7) - 3);
      start(a, $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 6) - 3));
      if ($urandom_range(0, 11) == 0) begin
        repeat ($urandom_range(0, 8)) tick();
        do_reset($urandom_range(1, 2));
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (20) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
